// File: rtl/ram_addr_sequencer_pkg.sv
// Shared FSM encoding and address-range helpers for the RAM address sequencer.
package ram_addr_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    POST  = 2'd2,
    FILL  = 2'd3
  } state_t;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int ADDR_MAX       = (1 << ADDR_W_DEFAULT) - 1;

  function automatic int addr_max_of(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/ram_addr_sequencer_edge_pulse.sv
// Rising-edge detector for a debounced button level; one-cycle pulse per press.
module ram_addr_sequencer_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;
  logic armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level;
      armed   <= 1'b1;
    end
  end

  // armed masks the first cycle after reset so a button held through release is not an edge
  assign pulse = armed & level & ~level_q;

endmodule

// File: rtl/ram_addr_sequencer.sv
// RAM address / write-enable sequencer: manual step, single write, auto-scan and bulk fill.
// addr, we and busy are all registered; events are taken one per cycle in IDLE only.
module ram_addr_sequencer
  import ram_addr_sequencer_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int SCAN_DIV = 50_000_000,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        dir,
  input  logic        wr_btn,
  input  logic        fill_btn,
  input  logic        scan_en,
  output logic [15:0] addr,
  output logic        we,
  output logic        busy
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(addr_max_of(ADDR_W));
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               we_nxt, busy_nxt;
  logic               step_ev, wr_ev, fill_ev;

  ram_addr_sequencer_edge_pulse u_step (.clk(clk), .reset(reset), .level(step_btn), .pulse(step_ev));
  ram_addr_sequencer_edge_pulse u_wr   (.clk(clk), .reset(reset), .level(wr_btn),   .pulse(wr_ev));
  ram_addr_sequencer_edge_pulse u_fill (.clk(clk), .reset(reset), .level(fill_btn), .pulse(fill_ev));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt    <= '0;
      we     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      cnt    <= cnt_nxt;
      we     <= we_nxt;
      busy   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    cnt_nxt   = '0;
    we_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // prescaler only runs in IDLE; any taken event below clears it again
        if (scan_en && cnt != CNT_LAST) cnt_nxt = cnt + CNT_W'(1);
        if (fill_ev) begin
          state_nxt = FILL;
          addr_nxt  = '0;
          we_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else if (wr_ev) begin
          state_nxt = WRITE;
          we_nxt    = 1'b1;
          cnt_nxt   = '0;
        end else if (step_ev) begin
          addr_nxt = dir ? addr_q - ONE : addr_q + ONE;
          cnt_nxt  = '0;
        end else if (scan_en && cnt == CNT_LAST) begin
          addr_nxt = addr_q + ONE;
        end
      end
      WRITE: state_nxt = POST;
      POST: begin
        if (AUTO_INC) addr_nxt = addr_q + ONE;
        state_nxt = IDLE;
      end
      FILL: begin
        if (addr_q == LAST) begin
          addr_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          addr_nxt = addr_q + ONE;
          we_nxt   = 1'b1;
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign addr = 16'(addr_q);

endmodule

// File: tb/tb_ram_addr_sequencer.sv
// Scoreboarded random bench: two instances (auto-increment on/off) share all inputs.
module tb_ram_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_btn = 1'b0, dir = 1'b0, wr_btn = 1'b0, fill_btn = 1'b0, scan_en = 1'b0;
  logic [15:0] addr_a, addr_b;
  logic        we_a, we_b, busy_a, busy_b;

  int n_pass = 0;
  int n_total = 0;
  int qa[$];
  int qb[$];
  int m_a = 0;
  int m_b = 0;

  always #5 clk = ~clk;

  ram_addr_sequencer #(.ADDR_W(8), .SCAN_DIV(4), .AUTO_INC(1'b1)) dut_a (
    .clk(clk), .reset(reset), .step_btn(step_btn), .dir(dir), .wr_btn(wr_btn),
    .fill_btn(fill_btn), .scan_en(scan_en), .addr(addr_a), .we(we_a), .busy(busy_a));

  ram_addr_sequencer #(.ADDR_W(8), .SCAN_DIV(4), .AUTO_INC(1'b0)) dut_b (
    .clk(clk), .reset(reset), .step_btn(step_btn), .dir(dir), .wr_btn(wr_btn),
    .fill_btn(fill_btn), .scan_en(scan_en), .addr(addr_b), .we(we_b), .busy(busy_b));

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // monitor: every write-enable cycle must match the next expected write address
  always @(negedge clk) begin
    if (!reset) begin
      if (we_a) begin
        if (qa.size() == 0) chk("unexpected write a", int'(addr_a), -1);
        else chk("write addr a", int'(addr_a), qa.pop_front());
      end
      if (we_b) begin
        if (qb.size() == 0) chk("unexpected write b", int'(addr_b), -1);
        else chk("write addr b", int'(addr_b), qb.pop_front());
      end
    end
  end

  task automatic check_addr(input string name);
    chk({name, " addr a"}, int'(addr_a), m_a);
    chk({name, " addr b"}, int'(addr_b), m_b);
  endtask

  task automatic press(input bit s, input bit w, input bit f, input bit d);
    dir = d; step_btn = s; wr_btn = w; fill_btn = f;
    @(posedge clk); #1;
    step_btn = 1'b0; wr_btn = 1'b0; fill_btn = 1'b0;
  endtask

  task automatic do_step(input bit d);
    press(1'b1, 1'b0, 1'b0, d);
    m_a = (m_a + (d ? 255 : 1)) % 256;
    m_b = (m_b + (d ? 255 : 1)) % 256;
    check_addr("step");
    @(posedge clk); #1;
  endtask

  task automatic do_write();
    qa.push_back(m_a);
    qb.push_back(m_b);
    press(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    m_a = (m_a + 1) % 256;
    repeat (2) @(posedge clk);
    #1;
    check_addr("write");
  endtask

  task automatic do_fill(input bit poke);
    int cyc;
    for (int i = 0; i < 256; i++) begin
      qa.push_back(i);
      qb.push_back(i);
    end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    cyc = 0;
    while (busy_a && cyc < 300) begin
      if (poke && cyc == 100) step_btn = 1'b1;
      if (cyc == 101) step_btn = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    step_btn = 1'b0;
    chk("fill busy cycles", cyc, 256);
    m_a = 0;
    m_b = 0;
    check_addr("after fill");
    chk("busy b after fill", int'(busy_b), 0);
  endtask

  initial begin
    int cyc;
    #12;
    chk("reset addr a", int'(addr_a), 0);
    chk("reset we a", int'(we_a), 0);
    chk("reset busy a", int'(busy_a), 0);
    chk("reset addr b", int'(addr_b), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    do_step(1'b0); do_step(1'b0); do_step(1'b0); do_step(1'b1);
    do_step(1'b1); do_step(1'b1);
    do_step(1'b1);
    do_step(1'b0);

    for (int i = 0; i < 16; i++) do_step(1'b0);
    do_write();

    do_fill(1'b1);

    // auto-scan: one step every 4 cycles, nothing in between
    scan_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (3) @(posedge clk);
      #1;
      check_addr("scan hold");
      @(posedge clk); #1;
      m_a = (m_a + 1) % 256;
      m_b = (m_b + 1) % 256;
      check_addr("scan tick");
    end
    qa.push_back(m_a);
    qb.push_back(m_b);
    step_btn = 1'b1; wr_btn = 1'b1; dir = 1'b0;
    @(posedge clk); #1;
    scan_en = 1'b0; step_btn = 1'b0; wr_btn = 1'b0;
    m_a = (m_a + 1) % 256;
    repeat (2) @(posedge clk);
    #1;
    check_addr("write beats step");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: do_step(1'($urandom_range(0, 1)));
        3, 4:    do_write();
        default: if ($urandom_range(0, 2) == 0) do_fill(1'b0); else do_step(1'b1);
      endcase
    end

    // reset in the middle of a fill with fill_btn still held
    for (int i = 0; i < 256; i++) begin
      qa.push_back(i);
      qb.push_back(i);
    end
    fill_btn = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (int'(addr_a) != 128 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("fill reached 0x80", int'(addr_a), 128);
    reset = 1'b1;
    #1;
    chk("async reset addr a", int'(addr_a), 0);
    chk("async reset we a", int'(we_a), 0);
    chk("async reset busy a", int'(busy_a), 0);
    chk("async reset addr b", int'(addr_b), 0);
    qa.delete();
    qb.delete();
    m_a = 0;
    m_b = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("held fill no restart busy", int'(busy_a), 0);
    check_addr("held fill no restart");
    fill_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("pending writes a", qa.size(), 0);
    chk("pending writes b", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
